// File: rtl/soc_bus_pkg.sv
// Shared types, constants and helpers for the SoC bus fabric.
package soc_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACKW = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_ACK_MODE = 4'hF;
  localparam int         TMO_W         = 10;

  // Slave index width; a single-slave fabric still needs one bit to index.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [31:0] byte_swap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

endpackage

// File: rtl/soc_bus_fabric_if.sv
// Core-side and slave-side signals of the bus fabric, plus the FSM debug state.
// Handshake: a core access is valid in any cycle with m_req=1; while m_stall=1 the core holds
// m_addr/m_we/m_wdata/m_req, the first cycle with m_stall=0 completes it, and m_rdata/m_err
// belong to that access in the following cycle. Slaves see s_sel for the whole access.
interface soc_bus_fabric_if
  import soc_bus_pkg::*;
#(
  parameter int NSLV = 4,
  parameter int AW   = 32
);
  logic [AW-1:0]        m_addr;
  logic                 m_req;
  logic [3:0]           m_we;
  logic [31:0]          m_wdata;
  logic [31:0]          m_rdata;
  logic                 m_stall;
  logic                 m_err;
  logic [NSLV-1:0]      s_sel;
  logic [AW-1:0]        s_addr;
  logic [3:0]           s_we;
  logic [NSLV*32-1:0]   s_wdata;
  logic [NSLV*32-1:0]   s_rdata;
  logic [NSLV-1:0]      s_ack;
  state_t               dbg_state;

  modport slave (
    input  m_addr, m_req, m_we, m_wdata, s_rdata, s_ack,
    output m_rdata, m_stall, m_err, s_sel, s_addr, s_we, s_wdata, dbg_state
  );

  modport master (
    output m_addr, m_req, m_we, m_wdata, s_rdata, s_ack,
    input  m_rdata, m_stall, m_err, s_sel, s_addr, s_we, s_wdata, dbg_state
  );
endinterface

// File: rtl/bus_wait_ctrl.sv
// Access sequencer: wait-state countdown, ack wait and ack timeout for one access at a time.
module bus_wait_ctrl
  import soc_bus_pkg::*;
#(
  parameter int TMO_CYCLES = 255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [3:0] wait_code_i,
  input  logic       ack_i,
  output logic       stall_o,
  output logic       done_o,
  output logic       timeout_o,
  output logic       busy_o,
  output state_t     state_o
);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  // tmo_q counts stall cycles already spent, the request cycle included.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    stall_o   = 1'b0;
    done_o    = 1'b0;
    timeout_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (wait_code_i == 4'h0) begin
            done_o = 1'b1;
          end else if (wait_code_i == WAIT_ACK_MODE) begin
            if (ack_i) begin
              done_o = 1'b1;
            end else begin
              stall_o = 1'b1;
              tmo_d   = TMO_W'(1);
              state_d = ACKW;
            end
          end else begin
            stall_o = 1'b1;
            cnt_d   = wait_code_i - 4'd1;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q != 4'h0) begin
          stall_o = 1'b1;
          cnt_d   = cnt_q - 4'd1;
        end else begin
          done_o  = 1'b1;
          state_d = IDLE;
        end
      end
      ACKW: begin
        if (ack_i) begin
          done_o  = 1'b1;
          state_d = IDLE;
        end else if (tmo_q == TMO_W'(TMO_CYCLES)) begin
          timeout_o = 1'b1;
          state_d   = IDLE;
        end else begin
          stall_o = 1'b1;
          tmo_d   = tmo_q + TMO_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o  = (state_q != IDLE);
  assign state_o = state_q;

endmodule

// File: rtl/soc_bus_fabric.sv
// N-slave bus fabric: address decode, per-slave byte swap, registered read-back select, stall/error.
module soc_bus_fabric
  import soc_bus_pkg::*;
#(
  parameter int                 NSLV       = 4,
  parameter int                 AW         = 32,
  parameter logic [NSLV*8-1:0]  SLV_BASE   = {8'he2, 8'he1, 8'h40, 8'h00},
  parameter logic [NSLV*8-1:0]  SLV_MASK   = {NSLV{8'hff}},
  parameter logic [NSLV-1:0]    SLV_SWAP   = 4'b1100,
  parameter logic [NSLV*4-1:0]  SLV_WAIT   = 16'h0000,
  parameter int                 TMO_CYCLES = 255,
  parameter bit                 MISS_ERR   = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  soc_bus_fabric_if.slave  bus
);

  localparam int IW = idx_w(NSLV);

  logic [7:0]      slot;
  logic [NSLV-1:0] hit;
  logic            hit_any;
  logic [IW-1:0]   hit_idx, act_idx, cur_q, sel_idx_q;
  logic            sel_v_q, err_q;
  logic [3:0]      wait_code;
  logic            act_ack, start, in_txn, we_en;
  logic            stall, done, timeout, busy;
  logic [31:0]     rdata;

  assign slot = bus.m_addr[AW-1:AW-8];

  // Scanning downwards lets the lowest-index hit overwrite any higher one.
  always_comb begin
    hit     = '0;
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      hit[i] = ((slot ^ SLV_BASE[i*8 +: 8]) & SLV_MASK[i*8 +: 8]) == 8'h00;
      if (hit[i]) begin
        hit_any = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  assign act_idx = busy ? cur_q : hit_idx;

  always_comb begin
    wait_code = 4'h0;
    act_ack   = 1'b0;
    for (int i = 0; i < NSLV; i++) begin
      if (act_idx == IW'(i)) begin
        wait_code = SLV_WAIT[i*4 +: 4];
        act_ack   = bus.s_ack[i];
      end
    end
  end

  assign start = bus.m_req & hit_any & ~busy;

  bus_wait_ctrl #(.TMO_CYCLES(TMO_CYCLES)) u_ctrl (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start),
    .wait_code_i (wait_code),
    .ack_i       (act_ack),
    .stall_o     (stall),
    .done_o      (done),
    .timeout_o   (timeout),
    .busy_o      (busy),
    .state_o     (bus.dbg_state)
  );

  // Ack-mode slaves see write enables for the whole access; wait-state slaves only on completion.
  assign in_txn = start | busy;
  assign we_en  = done | (in_txn & (wait_code == WAIT_ACK_MODE));

  // Combinational outputs are gated by reset so they drop the moment rst_i falls.
  assign bus.m_stall = stall & rst_i;
  assign bus.s_sel   = (in_txn & rst_i) ? (NSLV'(1) << act_idx) : '0;
  assign bus.s_we    = (we_en & rst_i) ? bus.m_we : 4'h0;
  assign bus.s_addr  = bus.m_addr;

  for (genvar g = 0; g < NSLV; g++) begin : g_wdata
    assign bus.s_wdata[g*32 +: 32] = SLV_SWAP[g] ? byte_swap32(bus.m_wdata) : bus.m_wdata;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cur_q     <= '0;
      sel_v_q   <= 1'b0;
      sel_idx_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (start) cur_q <= hit_idx;
      sel_v_q   <= done;
      sel_idx_q <= act_idx;
      err_q     <= timeout | (MISS_ERR & bus.m_req & ~hit_any & ~busy);
    end
  end

  always_comb begin
    rdata = 32'h0;
    for (int i = 0; i < NSLV; i++) begin
      if (sel_v_q && sel_idx_q == IW'(i)) begin
        rdata = SLV_SWAP[i] ? byte_swap32(bus.s_rdata[i*32 +: 32]) : bus.s_rdata[i*32 +: 32];
      end
    end
  end

  assign bus.m_rdata = rdata;
  assign bus.m_err   = err_q;

endmodule

// File: tb/tb_soc_bus_fabric.sv
// Directed bench for soc_bus_fabric: single-cycle vector table plus multi-cycle sequences.
module tb_soc_bus_fabric;
  import soc_bus_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  soc_bus_fabric_if #(.NSLV(4), .AW(32)) bus_if ();

  // Slave 0 (boot) is ack mode with an 8-cycle timeout, slave 3 (vga) has 3 wait states.
  soc_bus_fabric #(
    .NSLV       (4),
    .AW         (32),
    .SLV_BASE   ({8'he2, 8'he1, 8'h40, 8'h00}),
    .SLV_MASK   ({4{8'hff}}),
    .SLV_SWAP   (4'b1100),
    .SLV_WAIT   (16'h300F),
    .TMO_CYCLES (8),
    .MISS_ERR   (1'b1)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus_if)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    logic        req;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic        exp_stall;
    logic [3:0]  exp_sel;
    logic [3:0]  exp_we;
    logic [31:0] exp_wd1;
    logic [31:0] exp_wd2;
    logic [31:0] exp_rdata_nx;
    logic        exp_err_nx;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic r, input logic [3:0] w,
                       input logic [31:0] d, input logic [3:0] ack);
    bus_if.m_addr  = a;
    bus_if.m_req   = r;
    bus_if.m_we    = w;
    bus_if.m_wdata = d;
    bus_if.s_ack   = ack;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h4000_0010, 1'b1, 4'h0, 32'h0000_0000, 1'b0, 4'b0010, 4'h0,
                32'h0000_0000, 32'h0000_0000, 32'h1122_3344, 1'b0};
    vecs[1] = '{32'hE100_0020, 1'b1, 4'h0, 32'hA5A5_0F0F, 1'b0, 4'b0100, 4'h0,
                32'hA5A5_0F0F, 32'h0F0F_A5A5, 32'hDDCC_BBAA, 1'b0};
    vecs[2] = '{32'hE100_0020, 1'b1, 4'hF, 32'h0102_0304, 1'b0, 4'b0100, 4'hF,
                32'h0102_0304, 32'h0403_0201, 32'hDDCC_BBAA, 1'b0};
    vecs[3] = '{32'h9000_0000, 1'b1, 4'h0, 32'h0000_0000, 1'b0, 4'b0000, 4'h0,
                32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[4] = '{32'h4000_0000, 1'b0, 4'hF, 32'hDEAD_BEEF, 1'b0, 4'b0000, 4'h0,
                32'hDEAD_BEEF, 32'hEFBE_ADDE, 32'h0000_0000, 1'b0};
    vecs[5] = '{32'h4000_0000, 1'b1, 4'h3, 32'h1234_5678, 1'b0, 4'b0010, 4'h3,
                32'h1234_5678, 32'h7856_3412, 32'h1122_3344, 1'b0};
    vecs[6] = '{32'h4100_0000, 1'b1, 4'h0, 32'h0000_0000, 1'b0, 4'b0000, 4'h0,
                32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[7] = '{32'hE1FF_FFFC, 1'b1, 4'h0, 32'h0000_0000, 1'b0, 4'b0100, 4'h0,
                32'h0000_0000, 32'h0000_0000, 32'hDDCC_BBAA, 1'b0};

    bus_if.s_rdata = {32'h5566_7788, 32'hAABB_CCDD, 32'h1122_3344, 32'h0BAD_F00D};
    drive(32'h4000_0000, 1'b1, 4'hF, 32'h0, 4'h0);

    // Reset held with a live request: every control output must stay quiet.
    #12;
    chk("rst stall", 32'(bus_if.m_stall), 32'h0);
    chk("rst sel",   32'(bus_if.s_sel),   32'h0);
    chk("rst we",    32'(bus_if.s_we),    32'h0);
    chk("rst rdata", bus_if.m_rdata,      32'h0);
    chk("rst err",   32'(bus_if.m_err),   32'h0);
    @(negedge clk_i);
    rst_i = 1'b1;
    drive(32'h0, 1'b0, 4'h0, 32'h0, 4'h0);

    for (int k = 0; k < 8; k++) begin
      cyc();
      drive(vecs[k].addr, vecs[k].req, vecs[k].we, vecs[k].wdata, 4'h0);
      @(negedge clk_i);
      if (k > 0) begin
        chk($sformatf("v%0d rdata", k - 1), bus_if.m_rdata, vecs[k-1].exp_rdata_nx);
        chk($sformatf("v%0d err", k - 1), 32'(bus_if.m_err), 32'(vecs[k-1].exp_err_nx));
      end
      chk($sformatf("v%0d stall", k), 32'(bus_if.m_stall), 32'(vecs[k].exp_stall));
      chk($sformatf("v%0d sel", k),   32'(bus_if.s_sel),   32'(vecs[k].exp_sel));
      chk($sformatf("v%0d we", k),    32'(bus_if.s_we),    32'(vecs[k].exp_we));
      chk($sformatf("v%0d wd1", k),   bus_if.s_wdata[63:32], vecs[k].exp_wd1);
      chk($sformatf("v%0d wd2", k),   bus_if.s_wdata[95:64], vecs[k].exp_wd2);
    end
    cyc();
    drive(32'h0, 1'b0, 4'h0, 32'h0, 4'h0);
    @(negedge clk_i);
    chk("v7 rdata", bus_if.m_rdata, vecs[7].exp_rdata_nx);
    chk("v7 err", 32'(bus_if.m_err), 32'(vecs[7].exp_err_nx));

    // Three wait states on slave 3: stall 3 cycles, write enable only in the 4th.
    for (int c = 1; c <= 4; c++) begin
      cyc();
      if (c == 1) drive(32'hE200_0000, 1'b1, 4'hF, 32'hCAFE_F00D, 4'h0);
      @(negedge clk_i);
      chk($sformatf("ws c%0d stall", c), 32'(bus_if.m_stall), (c < 4) ? 32'h1 : 32'h0);
      chk($sformatf("ws c%0d we", c),    32'(bus_if.s_we),    (c == 4) ? 32'hF : 32'h0);
      chk($sformatf("ws c%0d sel", c),   32'(bus_if.s_sel),   32'h8);
    end
    chk("ws wd3", bus_if.s_wdata[127:96], 32'h0DF0_FECA);
    cyc();
    drive(32'h0, 1'b0, 4'h0, 32'h0, 4'h0);
    @(negedge clk_i);
    chk("ws rdata", bus_if.m_rdata, 32'h8877_6655);
    chk("ws err", 32'(bus_if.m_err), 32'h0);

    // Ack mode without ack: 8 stall cycles, then an unstalled cycle, then one error pulse.
    for (int c = 1; c <= 9; c++) begin
      cyc();
      if (c == 1) drive(32'h0000_0100, 1'b1, 4'h0, 32'h0, 4'h0);
      @(negedge clk_i);
      chk($sformatf("tmo c%0d stall", c), 32'(bus_if.m_stall), (c <= 8) ? 32'h1 : 32'h0);
      if (c == 2) chk("tmo state", 32'(bus_if.dbg_state), 32'(ACKW));
    end
    cyc();
    drive(32'h0, 1'b0, 4'h0, 32'h0, 4'h0);
    @(negedge clk_i);
    chk("tmo err", 32'(bus_if.m_err), 32'h1);
    chk("tmo rdata", bus_if.m_rdata, 32'h0);
    cyc();
    @(negedge clk_i);
    chk("tmo err clr", 32'(bus_if.m_err), 32'h0);

    // Ack after two stall cycles; a stray ack from slave 1 in between is ignored.
    for (int c = 1; c <= 3; c++) begin
      cyc();
      drive(32'h0000_0200, 1'b1, 4'h0, 32'h0, (c == 2) ? 4'b0010 : (c == 3) ? 4'b0001 : 4'b0000);
      @(negedge clk_i);
      chk($sformatf("ack c%0d stall", c), 32'(bus_if.m_stall), (c < 3) ? 32'h1 : 32'h0);
    end
    cyc();
    drive(32'h0, 1'b0, 4'h0, 32'h0, 4'h0);
    @(negedge clk_i);
    chk("ack rdata", bus_if.m_rdata, 32'h0BAD_F00D);
    chk("ack err", 32'(bus_if.m_err), 32'h0);

    // Ack arriving in the request cycle completes without any stall.
    cyc();
    drive(32'h0000_0300, 1'b1, 4'h0, 32'h0, 4'b0001);
    @(negedge clk_i);
    chk("ack0 stall", 32'(bus_if.m_stall), 32'h0);
    chk("ack0 sel", 32'(bus_if.s_sel), 32'h1);
    cyc();
    drive(32'h0, 1'b0, 4'h0, 32'h0, 4'h0);
    @(negedge clk_i);
    chk("ack0 rdata", bus_if.m_rdata, 32'h0BAD_F00D);

    // Reset in the second cycle of an ack-mode stall, then a normal RAM read.
    cyc();
    drive(32'h0000_0400, 1'b1, 4'hF, 32'h0, 4'h0);
    @(negedge clk_i);
    chk("rs c1 stall", 32'(bus_if.m_stall), 32'h1);
    cyc();
    @(negedge clk_i);
    chk("rs c2 stall", 32'(bus_if.m_stall), 32'h1);
    rst_i = 1'b0;
    #1;
    chk("rs stall", 32'(bus_if.m_stall), 32'h0);
    chk("rs sel",   32'(bus_if.s_sel),   32'h0);
    chk("rs we",    32'(bus_if.s_we),    32'h0);
    chk("rs err",   32'(bus_if.m_err),   32'h0);
    chk("rs rdata", bus_if.m_rdata,      32'h0);
    chk("rs state", 32'(bus_if.dbg_state), 32'(IDLE));
    @(negedge clk_i);
    rst_i = 1'b1;
    drive(32'h0, 1'b0, 4'h0, 32'h0, 4'h0);
    cyc();
    drive(32'h4000_0010, 1'b1, 4'h0, 32'h0, 4'h0);
    @(negedge clk_i);
    chk("rs ram stall", 32'(bus_if.m_stall), 32'h0);
    chk("rs ram sel", 32'(bus_if.s_sel), 32'h2);
    cyc();
    drive(32'h0, 1'b0, 4'h0, 32'h0, 4'h0);
    @(negedge clk_i);
    chk("rs ram rdata", bus_if.m_rdata, 32'h1122_3344);
    chk("rs ram err", 32'(bus_if.m_err), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
